fdct_2d: RTL and testbench



---
 rtl/dct_pkg.sv | 29 ++
 rtl/dct_1d8.sv | 30 +++
 rtl/fdct_2d.sv | 129 ++++++++++++
 tb/tb_fdct_2d.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared widths, FSM states and the fixed-point cosine matrix for the 8x8 forward DCT.
package dct_pkg;

  localparam int SAMP_W    = 8;
  localparam int IN_W      = 9;
  localparam int ROW_W     = 16;
  localparam int COEF_W    = 16;
  localparam int DCT_ACC_W = 32;
  localparam int COEF_FRAC = 11;
  // Largest constant magnitude (1004) needs COEF_FRAC bits plus sign.
  localparam int CF_W      = COEF_FRAC + 1;

  typedef logic signed [CF_W-1:0] cf_t;

  typedef enum logic [1:0] {IDLE, ROW, COL, OUT} state_e;

  // C[k][n] = round(2^COEF_FRAC * c(k)/2 * cos((2n+1)k*pi/16)), c(0) = 1/sqrt(2).
  localparam cf_t DCT_C [8][8] = '{
    '{ 12'sd724,   12'sd724,   12'sd724,   12'sd724,   12'sd724,   12'sd724,   12'sd724,   12'sd724},
    '{ 12'sd1004,  12'sd851,   12'sd569,   12'sd200,  -12'sd200,  -12'sd569,  -12'sd851,  -12'sd1004},
    '{ 12'sd946,   12'sd392,  -12'sd392,  -12'sd946,  -12'sd946,  -12'sd392,   12'sd392,   12'sd946},
    '{ 12'sd851,  -12'sd200,  -12'sd1004, -12'sd569,   12'sd569,   12'sd1004,  12'sd200,  -12'sd851},
    '{ 12'sd724,  -12'sd724,  -12'sd724,   12'sd724,   12'sd724,  -12'sd724,  -12'sd724,   12'sd724},
    '{ 12'sd569,  -12'sd1004,  12'sd200,   12'sd851,  -12'sd851,  -12'sd200,   12'sd1004, -12'sd569},
    '{ 12'sd392,  -12'sd946,   12'sd946,  -12'sd392,  -12'sd392,   12'sd946,  -12'sd946,   12'sd392},
    '{ 12'sd200,  -12'sd569,   12'sd851,  -12'sd1004,  12'sd1004, -12'sd851,   12'sd569,  -12'sd200}
  };

endpackage

// File: rtl/dct_1d8.sv
// Combinational 8-point forward DCT: y_k = (sum_n C[k][n]*x_n + 2^(shift-1)) >>> shift.
module dct_1d8
  import dct_pkg::*;
#(
  parameter int ACC_W = DCT_ACC_W
) (
  input  logic signed [ROW_W-1:0] x_i [8],
  input  logic        [4:0]       shift_i,
  output logic signed [ACC_W-1:0] y_o [8]
);

  function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [ACC_W-1:0] v,
                                                          input logic [4:0] sh);
    logic signed [ACC_W-1:0] half;
    half = ACC_W'(1) << (sh - 5'd1);
    return (v + half) >>> sh;
  endfunction

  logic signed [ACC_W-1:0] acc [8];

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      acc[k] = '0;
      for (int n = 0; n < 8; n++)
        acc[k] = acc[k] + ACC_W'(DCT_C[k][n]) * ACC_W'(x_i[n]);
      y_o[k] = round_shift(acc[k], shift_i);
    end
  end

endmodule

// File: rtl/fdct_2d.sv
// 8x8 forward 2D DCT: one time-multiplexed 1D engine does 8 row passes then 8 column passes.
// Define LEVEL_SHIFT_EN to take unsigned 0..255 samples and subtract 128 when latching.
module fdct_2d
  import dct_pkg::*;
#(
  parameter int ROW_SHIFT = 9,
  parameter int COL_SHIFT = 13,
  parameter int ACC_W     = DCT_ACC_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [511:0]  data_in,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [1023:0] data_out
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (COEF_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

  function automatic logic signed [COEF_W-1:0] sat_coef(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX) return COEF_W'(SAT_MAX);
    if (v < SAT_MIN) return COEF_W'(SAT_MIN);
    return COEF_W'(v);
  endfunction

  function automatic logic signed [IN_W-1:0] latch_sample(input logic [SAMP_W-1:0] b);
`ifdef LEVEL_SHIFT_EN
    return $signed({1'b0, b}) - IN_W'(128);
`else
    return IN_W'($signed(b));
`endif
  endfunction

  state_e                   state_q, state_d;
  logic [2:0]               cnt_q, cnt_d;
  logic                     accept;
  logic signed [IN_W-1:0]   in_q  [8][8];
  logic signed [ROW_W-1:0]  tr_q  [8][8];
  logic signed [COEF_W-1:0] out_q [8][8];
  logic signed [ROW_W-1:0]  eng_x [8];
  logic signed [ACC_W-1:0]  eng_y [8];
  logic [4:0]               eng_sh;

  // s_ready is gated by rst because the async reset already forces IDLE while rst is high.
  assign s_ready = (state_q == IDLE) && !rst;
  assign m_valid = (state_q == OUT);
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = ROW;
        cnt_d   = '0;
      end
      ROW: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = COL;
      end
      COL: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = OUT;
      end
      OUT: if (m_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Engine reads the latched block in ROW and the transpose buffer in COL.
  always_comb begin
    eng_sh = (state_q == COL) ? 5'(COL_SHIFT) : 5'(ROW_SHIFT);
    for (int n = 0; n < 8; n++)
      eng_x[n] = (state_q == COL) ? tr_q[cnt_q][n] : ROW_W'(in_q[cnt_q][n]);
  end

  dct_1d8 #(.ACC_W(ACC_W)) u_dct_1d8 (
    .x_i     (eng_x),
    .shift_i (eng_sh),
    .y_o     (eng_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) begin
          in_q[r][c]  <= '0;
          tr_q[r][c]  <= '0;
          out_q[r][c] <= '0;
        end
      end
    end else begin
      if (accept) begin
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 8; c++)
            in_q[r][c] <= latch_sample(data_in[8*(8*r+c) +: 8]);
      end
      if (state_q == ROW) begin
        for (int k = 0; k < 8; k++)
          tr_q[k][cnt_q] <= ROW_W'(eng_y[k]);
      end
      if (state_q == COL) begin
        for (int u = 0; u < 8; u++)
          out_q[u][cnt_q] <= sat_coef(eng_y[u]);
      end
    end
  end

  always_comb begin
    data_out = '0;
    for (int u = 0; u < 8; u++)
      for (int v = 0; v < 8; v++)
        data_out[COEF_W*(8*u+v) +: COEF_W] = out_q[u][v];
  end

endmodule

// File: tb/tb_fdct_2d.sv
// Bench for fdct_2d: directed and random blocks against a reference 2D DCT built from
// cosine constants computed at run time; also backpressure, throughput and mid-block reset.
module tb_fdct_2d;

  localparam int ROW_SH = 9;
  localparam int COL_SH = 13;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s_valid = 1'b0;
  logic          m_ready = 1'b0;
  logic [511:0]  data_in = '0;
  logic          s_ready;
  logic          m_valid;
  logic [1023:0] data_out;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cm   [8][8];
  int     samp [8][8];

  fdct_2d dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .data_in  (data_in),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  function automatic void init_cos();
    real ck, v;
    for (int k = 0; k < 8; k++) begin
      for (int n = 0; n < 8; n++) begin
        ck = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
        v  = 2048.0 * ck / 2.0 * $cos(real'((2 * n + 1) * k) * 3.14159265358979 / 16.0);
        cm[k][n] = (v >= 0.0) ? longint'($floor(v + 0.5)) : -longint'($floor(-v + 0.5));
      end
    end
  endfunction

  function automatic logic [7:0] enc(input int v);
`ifdef LEVEL_SHIFT_EN
    return 8'(v + 128);
`else
    return 8'(v);
`endif
  endfunction

  function automatic int dec(input logic [7:0] b);
`ifdef LEVEL_SHIFT_EN
    return int'(b) - 128;
`else
    return int'($signed(b));
`endif
  endfunction

  function automatic void fill_const(input int v);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        samp[r][c] = v;
  endfunction

  function automatic void fill_rand(input bit extremes);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (extremes) samp[r][c] = ($urandom_range(0, 1) != 0) ? 127 : -128;
        else          samp[r][c] = dec(8'($urandom_range(0, 255)));
  endfunction

  function automatic logic [511:0] pack_in();
    logic [511:0] p;
    p = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        p[8*(8*r+c) +: 8] = enc(samp[r][c]);
    return p;
  endfunction

  // Separable transform of samp: rows first (keep 2 fraction bits), then columns.
  function automatic logic [1023:0] model();
    longint acc, val;
    longint rr [8][8];
    logic [1023:0] p;
    p = '0;
    for (int y = 0; y < 8; y++) begin
      for (int k = 0; k < 8; k++) begin
        acc = 0;
        for (int n = 0; n < 8; n++) acc += cm[k][n] * samp[y][n];
        rr[y][k] = longint'(16'((acc + (longint'(1) << (ROW_SH - 1))) >>> ROW_SH));
        if (rr[y][k] > 32767) rr[y][k] -= 65536;
      end
    end
    for (int u = 0; u < 8; u++) begin
      for (int v = 0; v < 8; v++) begin
        acc = 0;
        for (int y = 0; y < 8; y++) acc += cm[u][y] * rr[y][v];
        val = (acc + (longint'(1) << (COL_SH - 1))) >>> COL_SH;
        if (val > 32767)  val = 32767;
        if (val < -32768) val = -32768;
        p[16*(8*u+v) +: 16] = 16'(val);
      end
    end
    return p;
  endfunction

  function automatic string diff_str(input logic [1023:0] a, input logic [1023:0] b);
    for (int i = 0; i < 64; i++)
      if (a[16*i +: 16] !== b[16*i +: 16])
        return $sformatf("coef(%0d,%0d) got %0d, expected %0d", i / 8, i % 8,
                         $signed(a[16*i +: 16]), $signed(b[16*i +: 16]));
    return "identical";
  endfunction

  // Offers one block, waits for the result and completes the output handshake.
  // lat is the number of edges from accept to m_valid, or -1 on timeout.
  task automatic run_block(input logic [511:0] d, input bit rnd_ready,
                           output logic [1023:0] got, output int lat);
    bit acc;
    acc = 1'b0;
    lat = -1;
    got = '0;
    data_in = d;
    s_valid = 1'b1;
    for (int w = 0; w < 40 && !acc; w++) begin
      if (s_ready) acc = 1'b1;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    if (acc) begin
      for (int t = 1; t <= 40; t++) begin
        if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        if (m_valid) begin
          lat = t;
          break;
        end
      end
      m_ready = 1'b0;
      got = data_out;
      if (lat > 0) begin
        for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
          @(posedge clk); #1;
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready: got %b, expected 0", s_ready); end
    n_checks++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b, expected 0", m_valid); end
    n_checks++;
    if (data_out !== '0) begin n_fail++; $display("FAIL reset_data_out: %s", diff_str(data_out, '0)); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (s_ready !== 1'b1) begin n_fail++; $display("FAIL release_s_ready: got %b, expected 1", s_ready); end
    n_checks++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL release_m_valid: got %b, expected 0", m_valid); end
  endtask

  task automatic test_directed();
    logic [1023:0] got, lit, ex;
    int lat, c;
    int ix [4] = '{0, 1, 8, 9};
    int ev [4] = '{8, 11, 11, 15};

    fill_const(0);
    run_block(pack_in(), 1'b0, got, lat);
    n_checks++;
    if (lat != 16) begin n_fail++; $display("FAIL zero_latency: got %0d, expected 16", lat); end
    n_checks++;
    if (got !== '0) begin n_fail++; $display("FAIL zero_block: %s", diff_str(got, '0)); end
    n_checks++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL m_valid_after_handshake: got %b, expected 0", m_valid); end

    fill_const(10);
    run_block(pack_in(), 1'b0, got, lat);
    lit = '0;
    lit[15:0] = 16'd80;
    n_checks++;
    if (got !== lit) begin n_fail++; $display("FAIL plus10_block: %s", diff_str(got, lit)); end
    n_checks++;
    if (lat != 16) begin n_fail++; $display("FAIL plus10_latency: got %0d, expected 16", lat); end

    fill_const(-128);
    run_block(pack_in(), 1'b0, got, lat);
    lit = '0;
    lit[15:0] = 16'hFC00;
    n_checks++;
    if (got !== lit) begin n_fail++; $display("FAIL minus128_block: %s", diff_str(got, lit)); end

    fill_const(0);
    samp[0][0] = 64;
    ex = model();
    run_block(pack_in(), 1'b0, got, lat);
    for (int j = 0; j < 4; j++) begin
      c = int'($signed(got[16*ix[j] +: 16]));
      n_checks++;
      if (c < ev[j] - 1 || c > ev[j] + 1) begin
        n_fail++;
        $display("FAIL impulse_coef(%0d,%0d): got %0d, expected %0d +/-1", ix[j] / 8, ix[j] % 8, c, ev[j]);
      end
    end
    n_checks++;
    if (got !== ex) begin n_fail++; $display("FAIL impulse_model: %s", diff_str(got, ex)); end

`ifdef LEVEL_SHIFT_EN
    run_block({64{8'd128}}, 1'b0, got, lat);
    n_checks++;
    if (got !== '0) begin n_fail++; $display("FAIL ls_raw128: %s", diff_str(got, '0)); end
    run_block({64{8'd138}}, 1'b0, got, lat);
    lit = '0;
    lit[15:0] = 16'd80;
    n_checks++;
    if (got !== lit) begin n_fail++; $display("FAIL ls_raw138: %s", diff_str(got, lit)); end
`endif
  endtask

  task automatic test_random();
    logic [1023:0] got, ex;
    int lat;
    for (int b = 0; b < 12; b++) begin
      fill_rand(b >= 9);
      ex = model();
      run_block(pack_in(), 1'b1, got, lat);
      n_checks++;
      if (lat != 16) begin n_fail++; $display("FAIL random_latency[%0d]: got %0d, expected 16", b, lat); end
      n_checks++;
      if (got !== ex) begin n_fail++; $display("FAIL random_block[%0d]: %s", b, diff_str(got, ex)); end
    end
  endtask

  task automatic test_backpressure();
    logic [511:0]  d1, d2;
    logic [1023:0] e1, e2, snap;
    bit ok, seen;
    int lat;
    fill_rand(1'b0); d1 = pack_in(); e1 = model();
    fill_rand(1'b0); d2 = pack_in(); e2 = model();
    ok = 1'b0;
    data_in = d1;
    s_valid = 1'b1;
    for (int w = 0; w < 40 && !ok; w++) begin
      if (s_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    data_in = d2;
    seen = 1'b0;
    for (int w = 0; w < 40 && !seen; w++) begin
      if (m_valid) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    n_checks++;
    if (!(ok && seen)) begin n_fail++; $display("FAIL bp_first_block: accepted %b, m_valid seen %b, expected 1 1", ok, seen); end
    snap = data_out;
    n_checks++;
    if (snap !== e1) begin n_fail++; $display("FAIL bp_first_data: %s", diff_str(snap, e1)); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_m_valid[%0d]: got %b, expected 1", i, m_valid); end
      n_checks++;
      if (data_out !== snap) begin n_fail++; $display("FAIL bp_hold_data[%0d]: %s", i, diff_str(data_out, snap)); end
      n_checks++;
      if (s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_s_ready[%0d]: got %b, expected 0", i, s_ready); end
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    n_checks++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_m_valid: got %b, expected 0", m_valid); end
    n_checks++;
    if (s_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_s_ready: got %b, expected 1", s_ready); end
    @(posedge clk); #1;
    s_valid = 1'b0;
    lat = -1;
    for (int t = 1; t <= 40; t++) begin
      @(posedge clk); #1;
      if (m_valid) begin lat = t; break; end
    end
    n_checks++;
    if (lat != 16) begin n_fail++; $display("FAIL bp_second_latency: got %0d, expected 16", lat); end
    n_checks++;
    if (data_out !== e2) begin n_fail++; $display("FAIL bp_second_data: %s", diff_str(data_out, e2)); end
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [511:0]  din [3];
    logic [1023:0] ex  [3];
    int acc_t [3];
    int idx, nout;
    bit take;
    for (int b = 0; b < 3; b++) begin
      fill_rand(1'b0);
      din[b] = pack_in();
      ex[b]  = model();
      acc_t[b] = -1;
    end
    idx = 0;
    nout = 0;
    data_in = din[0];
    s_valid = 1'b1;
    m_ready = 1'b1;
    for (int t = 0; t < 80 && nout < 3; t++) begin
      take = s_valid && s_ready;
      if (m_valid) begin
        n_checks++;
        if (data_out !== ex[nout]) begin n_fail++; $display("FAIL b2b_data[%0d]: %s", nout, diff_str(data_out, ex[nout])); end
        nout++;
      end
      @(posedge clk); #1;
      if (take) begin
        acc_t[idx] = t;
        idx++;
        if (idx < 3) data_in = din[idx];
        else s_valid = 1'b0;
      end
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    n_checks++;
    if (nout != 3) begin n_fail++; $display("FAIL b2b_count: got %0d blocks, expected 3", nout); end
    for (int b = 1; b < 3; b++) begin
      n_checks++;
      if (acc_t[b] - acc_t[b-1] != 18) begin
        n_fail++;
        $display("FAIL b2b_interval[%0d]: got %0d cycles, expected 18", b, acc_t[b] - acc_t[b-1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [1023:0] got, lit;
    int lat;
    bit ok, seen;
    fill_rand(1'b0);
    ok = 1'b0;
    data_in = pack_in();
    s_valid = 1'b1;
    for (int w = 0; w < 40 && !ok; w++) begin
      if (s_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    // Twelve edges past the accept puts the block at COL cnt=4.
    for (int i = 0; i < 12; i++) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    n_checks++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_m_valid: got %b, expected 0", m_valid); end
    n_checks++;
    if (s_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_s_ready: got %b, expected 0", s_ready); end
    n_checks++;
    if (data_out !== '0) begin n_fail++; $display("FAIL mid_rst_data_out: %s", diff_str(data_out, '0)); end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL mid_rst_no_output: got m_valid 1 after abort, expected 0"); end
    n_checks++;
    if (s_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_idle: got s_ready %b, expected 1", s_ready); end
    fill_const(10);
    run_block(pack_in(), 1'b0, got, lat);
    lit = '0;
    lit[15:0] = 16'd80;
    n_checks++;
    if (got !== lit) begin n_fail++; $display("FAIL mid_rst_next_block: %s", diff_str(got, lit)); end
    n_checks++;
    if (lat != 16) begin n_fail++; $display("FAIL mid_rst_next_latency: got %0d, expected 16", lat); end
  endtask

  initial begin
    init_cos();
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
